// File: rtl/mem_stream_reader_pkg.sv
// mem_stream_pkg: shared types and sizing helpers for the memory stream reader.
//   state_e        - engine FSM states (IDLE / READ / DRAIN)
//   fifo_depth_for - output buffer depth needed to sustain one beat per cycle
//                    across the RAM read latency (latency + 2)
//   len_width      - length/counter width for an address width: AWIDTH+1 bits,
//                    so a full-memory length of 2**AWIDTH is representable
package mem_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int fifo_depth_for(input int rd_latency);
        return rd_latency + 2;
    endfunction

    function automatic int len_width(input int awidth);
        return awidth + 1;
    endfunction

endpackage

// File: rtl/mem_stream_reader_if.sv
// mem_stream_reader_if: command, RAM read-port and output-stream signals of the
// memory stream reader, bundled as one interface.
//   cmd_valid/cmd_ready/cmd_addr/cmd_len   - command handshake (start, word count)
//   mem_req/mem_addr/mem_q                 - RAM read port (q arrives RD_LATENCY later)
//   out_valid/out_ready/out_data/out_last  - valid/ready output stream
//   busy                                   - engine is processing a command
// Modports: master = the reader engine, slave = its environment.
interface mem_stream_reader_if
    import mem_stream_pkg::*;
#(
    parameter int DWIDTH = 128,
    parameter int AWIDTH = 4
);
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [AWIDTH-1:0]              cmd_addr;
    logic [len_width(AWIDTH)-1:0]   cmd_len;

    logic                           mem_req;
    logic [AWIDTH-1:0]              mem_addr;
    logic [DWIDTH-1:0]              mem_q;

    logic                           out_valid;
    logic                           out_ready;
    logic [DWIDTH-1:0]              out_data;
    logic                           out_last;

    logic                           busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, mem_q, out_ready,
        output cmd_ready, mem_req, mem_addr, out_valid, out_data, out_last, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, mem_q, out_ready,
        input  cmd_ready, mem_req, mem_addr, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/mem_stream_reader_fifo.sv
// mem_stream_fifo: small synchronous FIFO organised as a shift register, so the
// head entry is always register 0 and drives the stream outputs directly.
//   clk, rst  - clock, asynchronous active-high reset
//   i_push    - write i_data this cycle (caller guarantees room)
//   i_data    - entry to store ({last, data} in the reader)
//   i_pop     - drop the head entry this cycle (caller guarantees not empty)
//   o_head    - current head entry (registered)
//   o_count   - number of stored entries
//   o_valid   - FIFO holds at least one entry
module mem_stream_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_valid
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_next [DEPTH];
    logic [CW-1:0]    w_wr_idx;

    // A push lands just behind the last surviving entry; when the head is
    // popped in the same cycle, everything moves down one slot first.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_wr_idx = i_pop ? (r_count - 1'b1) : r_count;
        w_next   = r_mem;
        if (i_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_next[i] = r_mem[i + 1];
            end
        end
        if (i_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == w_wr_idx) begin
                    w_next[i] = i_data;
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset here (normally memories are not) because
            // the head entry is a visible output that must read zero in reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
        end else begin
            r_mem   <= w_next;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[0];
    assign o_count = r_count;
    assign o_valid = (r_count != '0);

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: accepts a (start address, length) command, issues one RAM
// read per cycle while output-buffer credit allows, absorbs the fixed RAM read
// latency and presents the words as a valid/ready stream with a last flag.
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - mem_stream_reader_if.master: command port, RAM read port,
//               output stream and busy flag
// Parameters: DWIDTH data width, AWIDTH RAM address width, RD_LATENCY RAM
// address-to-q latency (1..2). The output buffer depth is derived, not set.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int DWIDTH     = 128,
    parameter int AWIDTH     = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_stream_reader_if.master     bus
);
    localparam int FIFO_DEPTH = fifo_depth_for(RD_LATENCY);
    localparam int LW         = len_width(AWIDTH);
    localparam int FCW        = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W      = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

    state_e                 r_state;
    logic                   r_cmd_ready;
    logic [AWIDTH-1:0]      r_addr;
    logic [LW-1:0]          r_remaining;
    logic [RD_LATENCY-1:0]  r_trk_vld;
    logic [RD_LATENCY-1:0]  r_trk_last;

    logic                   w_pop;
    logic                   w_issue;
    logic                   w_credit_ok;
    logic                   w_fifo_valid;
    logic [FCW-1:0]         w_fifo_count;
    logic [OCC_W-1:0]       w_inflight;
    logic [OCC_W-1:0]       w_occupancy;
    logic [DWIDTH:0]        w_head;

    // Reads already issued but whose data has not yet been written into the FIFO.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + OCC_W'(r_trk_vld[i]);
        end
    end

    // Every outstanding read already owns a FIFO slot, so a new read is issued
    // only if a slot is still free after this cycle's pop. A pop therefore
    // re-opens issue in the same cycle, and the FIFO can never overflow.
    assign w_pop       = w_fifo_valid && bus.out_ready;
    assign w_occupancy = OCC_W'(w_fifo_count) + w_inflight;
    assign w_credit_ok = (w_occupancy - OCC_W'(w_pop)) < OCC_W'(FIFO_DEPTH);
    assign w_issue     = (r_state == READ) && w_credit_ok;

    // Issue strobe and last tag travel alongside the RAM pipeline so that the
    // tail stage is high exactly in the cycle mem_q carries that read's word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trk_vld  <= '0;
            r_trk_last <= '0;
        end else begin
            r_trk_vld[0]  <= w_issue;
            r_trk_last[0] <= w_issue && (r_remaining == LW'(1));
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_trk_vld[i]  <= r_trk_vld[i-1];
                r_trk_last[i] <= r_trk_last[i-1];
            end
        end
    end

    mem_stream_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_trk_vld[RD_LATENCY-1]),
        .i_data  ({r_trk_last[RD_LATENCY-1], bus.mem_q}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_valid (w_fifo_valid)
    );

    // cmd_ready is a register so it is low throughout reset and only rises on
    // the first clock after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    // A zero-length command is consumed without leaving IDLE.
                    if (bus.cmd_valid && r_cmd_ready && (bus.cmd_len != '0)) begin
                        r_state     <= READ;
                        r_cmd_ready <= 1'b0;
                        r_addr      <= bus.cmd_addr;
                        r_remaining <= bus.cmd_len;
                    end
                end
                READ: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == LW'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && w_head[DWIDTH]) begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.mem_req   = w_issue;
    assign bus.mem_addr  = r_addr;
    assign bus.out_valid = w_fifo_valid;
    assign bus.out_data  = w_head[DWIDTH-1:0];
    assign bus.out_last  = w_head[DWIDTH];
    assign bus.busy      = (r_state != IDLE);

endmodule
